// File: rtl/dm_port_if.sv
// Requester-side bundle for one data-memory port of dm_arbiter.
// master = requester (CPU stage or DMA), slave = arbiter.
interface dm_port_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic          lock;
  logic [AW-1:0] addr;
  logic [DW-1:0] wd;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, lock, addr, wd,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, lock, addr, wd,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between two
// requesters, with registered read data and a bounded ownership lock.
module dm_arbiter #(
  parameter int AW       = 5,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 8
) (
  input  logic          clk,
  input  logic          rst,
  dm_port_if.slave      a,
  dm_port_if.slave      b,
  output logic          dm_we,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_wd,
  input  logic [DW-1:0] dm_rd
);

  localparam int CW = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_A,
    OWN_B
  } owner_t;

  owner_t        owner, owner_nxt;
  logic [CW-1:0] lock_cnt, cnt_nxt, cnt_inc;
  logic          last_gnt, last_nxt;
  logic          gnt_a, gnt_b, grant;
  logic          win_lock;
  owner_t        win_own;
  logic          rvalid_a, rvalid_b;
  logic [DW-1:0] rdata_a, rdata_b;

  // Grants are gated by rst so they drop in the same cycle reset rises.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!rst) begin
      if (owner == OWN_A && a.req) begin
        gnt_a = 1'b1;
      end else if (owner == OWN_B && b.req) begin
        gnt_b = 1'b1;
      end else if (a.req && b.req) begin
        gnt_a = last_gnt;
        gnt_b = !last_gnt;
      end else begin
        gnt_a = a.req;
        gnt_b = b.req;
      end
    end
  end

  assign grant    = gnt_a | gnt_b;
  assign win_lock = gnt_b ? b.lock : a.lock;
  assign win_own  = gnt_b ? OWN_B : OWN_A;
  assign cnt_inc  = (owner == win_own) ?
                    lock_cnt + CW'(1) : CW'(1);

  always_comb begin
    dm_we   = 1'b0;
    dm_addr = '0;
    dm_wd   = '0;
    if (gnt_a) begin
      dm_we   = a.we;
      dm_addr = a.addr;
      dm_wd   = a.wd;
    end else if (gnt_b) begin
      dm_we   = b.we;
      dm_addr = b.addr;
      dm_wd   = b.wd;
    end
  end

  always_comb begin
    owner_nxt = owner;
    cnt_nxt   = lock_cnt;
    last_nxt  = last_gnt;
    if (grant) begin
      last_nxt = gnt_b;
      if (win_lock && cnt_inc != CW'(LOCK_MAX)) begin
        owner_nxt = win_own;
        cnt_nxt   = cnt_inc;
      end else begin
        owner_nxt = OWN_NONE;
        cnt_nxt   = '0;
      end
    end else begin
      // No grant means the owner (if any) dropped req: release it.
      owner_nxt = OWN_NONE;
      cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner    <= OWN_NONE;
      lock_cnt <= '0;
      last_gnt <= 1'b1;
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
      rdata_a  <= '0;
      rdata_b  <= '0;
    end else begin
      owner    <= owner_nxt;
      lock_cnt <= cnt_nxt;
      last_gnt <= last_nxt;
      rvalid_a <= gnt_a & ~a.we;
      rvalid_b <= gnt_b & ~b.we;
      if (gnt_a && !a.we) rdata_a <= dm_rd;
      if (gnt_b && !b.we) rdata_b <= dm_rd;
    end
  end

  assign a.gnt    = gnt_a;
  assign b.gnt    = gnt_b;
  assign a.rvalid = rvalid_a;
  assign b.rvalid = rvalid_b;
  assign a.rdata  = rdata_a;
  assign b.rdata  = rdata_b;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural 32x32 data memory.
// Inputs change on negedge; outputs are sampled 1 time unit later.
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dm_we;
  logic [4:0]  dm_addr;
  logic [31:0] dm_wd;
  logic [31:0] dm_rd;
  logic [31:0] mem [32];
  int          errors = 0;
  int          checks = 0;

  dm_port_if #(.AW(5), .DW(32)) pa ();
  dm_port_if #(.AW(5), .DW(32)) pb ();

  dm_arbiter #(.AW(5), .DW(32), .LOCK_MAX(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (pa.slave),
    .b       (pb.slave),
    .dm_we   (dm_we),
    .dm_addr (dm_addr),
    .dm_wd   (dm_wd),
    .dm_rd   (dm_rd)
  );

  always #5 clk = ~clk;

  assign dm_rd = mem[dm_addr];
  always @(posedge clk) if (dm_we) mem[dm_addr] <= dm_wd;

  task automatic idle;
    pa.req = 0; pa.we = 0; pa.lock = 0; pa.addr = 0; pa.wd = 0;
    pb.req = 0; pb.we = 0; pb.lock = 0; pb.addr = 0; pb.wd = 0;
  endtask

  task automatic drv_a(input bit r, input bit w, input bit l,
                       input logic [4:0] ad, input logic [31:0] d);
    pa.req = r; pa.we = w; pa.lock = l; pa.addr = ad; pa.wd = d;
  endtask

  task automatic drv_b(input bit r, input bit w, input bit l,
                       input logic [4:0] ad, input logic [31:0] d);
    pb.req = r; pb.we = w; pb.lock = l; pb.addr = ad; pb.wd = d;
  endtask

  task automatic test_reset;
    idle();
    rst = 1;
    repeat (2) @(negedge clk);
    drv_a(1, 1, 0, 5'd1, 32'h1);
    drv_b(1, 0, 0, 5'd2, 32'h0);
    #1;
    checks++;
    if (pa.gnt !== 1'b0 || pb.gnt !== 1'b0) begin
      errors++;
      $display("FAIL rst_gnt: got a=%b b=%b need 0 0", pa.gnt, pb.gnt);
    end
    checks++;
    if (dm_we !== 1'b0) begin
      errors++;
      $display("FAIL rst_dm_we: got %b need 0", dm_we);
    end
    checks++;
    if (pa.rvalid !== 1'b0 || pb.rvalid !== 1'b0 ||
        pa.rdata !== 32'h0 || pb.rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_read: got %b %b %h %h need 0 0 0 0",
               pa.rvalid, pb.rvalid, pa.rdata, pb.rdata);
    end
    @(negedge clk);
    idle();
    rst = 0;
  endtask

  task automatic test_solo;
    @(negedge clk);
    drv_a(1, 1, 0, 5'd1, 32'h05633453);
    #1;
    checks++;
    if (pa.gnt !== 1'b1 || pb.gnt !== 1'b0 || dm_we !== 1'b1 ||
        dm_addr !== 5'd1 || dm_wd !== 32'h05633453) begin
      errors++;
      $display("FAIL solo_wr: got gnt=%b%b we=%b ad=%h wd=%h need 10 1 01 05633453",
               pa.gnt, pb.gnt, dm_we, dm_addr, dm_wd);
    end
    @(negedge clk);
    drv_a(1, 0, 0, 5'd1, 32'h0);
    #1;
    checks++;
    if (pa.gnt !== 1'b1 || pa.rvalid !== 1'b0 || dm_we !== 1'b0) begin
      errors++;
      $display("FAIL solo_rd: got gnt=%b rvalid=%b we=%b need 1 0 0",
               pa.gnt, pa.rvalid, dm_we);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (pa.rvalid !== 1'b1 || pa.rdata !== 32'h05633453) begin
      errors++;
      $display("FAIL solo_data: got %b %h need 1 05633453",
               pa.rvalid, pa.rdata);
    end
    checks++;
    if (pb.gnt !== 1'b0 || dm_we !== 1'b0 || dm_addr !== 5'd0 ||
        dm_wd !== 32'h0) begin
      errors++;
      $display("FAIL solo_nogrant: got gnt_b=%b we=%b ad=%h wd=%h need 0 0 0 0",
               pb.gnt, dm_we, dm_addr, dm_wd);
    end
    @(negedge clk);
    #1;
    checks++;
    if (pa.rvalid !== 1'b0 || pa.rdata !== 32'h05633453) begin
      errors++;
      $display("FAIL solo_hold: got %b %h need 0 05633453",
               pa.rvalid, pa.rdata);
    end
  endtask

  task automatic test_tie;
    bit exp_a;
    @(negedge clk);
    drv_a(1, 1, 0, 5'd0, 32'h01230000);
    @(negedge clk);
    drv_a(1, 1, 0, 5'd2, 32'h01232222);
    @(negedge clk);
    idle();
    rst = 1;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drv_a(1, 0, 0, 5'd0, 32'h0);
      drv_b(1, 0, 0, 5'd2, 32'h0);
      #1;
      exp_a = (i % 2 == 0);
      checks++;
      if (pa.gnt !== exp_a || pb.gnt !== !exp_a) begin
        errors++;
        $display("FAIL tie_gnt[%0d]: got a=%b b=%b need a=%b",
                 i, pa.gnt, pb.gnt, exp_a);
      end
      if (i > 0) begin
        checks++;
        if (!exp_a) begin
          if (pa.rvalid !== 1'b1 || pb.rvalid !== 1'b0 ||
              pa.rdata !== 32'h01230000) begin
            errors++;
            $display("FAIL tie_rd_a[%0d]: got %b %b %h need 1 0 01230000",
                     i, pa.rvalid, pb.rvalid, pa.rdata);
          end
        end else begin
          if (pb.rvalid !== 1'b1 || pa.rvalid !== 1'b0 ||
              pb.rdata !== 32'h01232222) begin
            errors++;
            $display("FAIL tie_rd_b[%0d]: got %b %b %h need 1 0 01232222",
                     i, pb.rvalid, pa.rvalid, pb.rdata);
          end
        end
      end
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (pb.rvalid !== 1'b1 || pb.rdata !== 32'h01232222 ||
        pa.rdata !== 32'h01230000) begin
      errors++;
      $display("FAIL tie_last: got %b %h %h need 1 01232222 01230000",
               pb.rvalid, pb.rdata, pa.rdata);
    end
  endtask

  task automatic test_lock;
    int  bcnt = 0;
    int  await = 0;
    int  at = -1;
    for (int c = 0; c < 16 && at < 0; c++) begin
      @(negedge clk);
      drv_b(1, 0, 1, 5'd2, 32'h0);
      drv_a(c >= 1, 0, 0, 5'd0, 32'h0);
      #1;
      if (pa.gnt === 1'b1) at = c;
      else begin
        if (pb.gnt === 1'b1) bcnt++;
        if (pa.req) await++;
      end
    end
    checks++;
    if (at != 8) begin
      errors++;
      $display("FAIL lock_a_cycle: got %0d need 8 (-1 = timeout)", at);
    end
    checks++;
    if (bcnt != 8) begin
      errors++;
      $display("FAIL lock_b_count: got %0d need 8", bcnt);
    end
    checks++;
    if (await != 7) begin
      errors++;
      $display("FAIL lock_a_wait: got %0d need 7", await);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_release;
    @(negedge clk);
    drv_b(1, 0, 1, 5'd2, 32'h0);
    #1;
    checks++;
    if (pb.gnt !== 1'b1) begin
      errors++;
      $display("FAIL rel_b0: got %b need 1", pb.gnt);
    end
    @(negedge clk);
    drv_a(1, 0, 0, 5'd0, 32'h0);
    #1;
    checks++;
    if (pb.gnt !== 1'b1 || pa.gnt !== 1'b0) begin
      errors++;
      $display("FAIL rel_own: got a=%b b=%b need 0 1", pa.gnt, pb.gnt);
    end
    @(negedge clk);
    pb.req = 0;
    #1;
    checks++;
    if (pa.gnt !== 1'b1) begin
      errors++;
      $display("FAIL rel_a_same: got %b need 1", pa.gnt);
    end
    @(negedge clk);
    idle();
    drv_b(1, 0, 1, 5'd2, 32'h0);
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (pa.gnt !== 1'b0 || pb.gnt !== 1'b0 || dm_we !== 1'b0 ||
        dm_addr !== 5'd0) begin
      errors++;
      $display("FAIL rel_idle: got %b %b %b %h need 0 0 0 00",
               pa.gnt, pb.gnt, dm_we, dm_addr);
    end
    @(negedge clk);
    drv_a(1, 0, 0, 5'd0, 32'h0);
    drv_b(1, 0, 0, 5'd2, 32'h0);
    #1;
    checks++;
    if (pa.gnt !== 1'b1 || pb.gnt !== 1'b0) begin
      errors++;
      $display("FAIL rel_none: got a=%b b=%b need 1 0", pa.gnt, pb.gnt);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    drv_a(1, 1, 0, 5'd3, 32'hDEADBEEF);
    #1;
    checks++;
    if (pa.gnt !== 1'b1 || dm_we !== 1'b1) begin
      errors++;
      $display("FAIL b2b_wr: got %b %b need 1 1", pa.gnt, dm_we);
    end
    @(negedge clk);
    idle();
    drv_b(1, 0, 0, 5'd3, 32'h0);
    #1;
    checks++;
    if (pb.gnt !== 1'b1 || pa.rvalid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_rd: got gnt_b=%b rvalid_a=%b need 1 0",
               pb.gnt, pa.rvalid);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (pb.rvalid !== 1'b1 || pb.rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL b2b_data: got %b %h need 1 deadbeef",
               pb.rvalid, pb.rdata);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    drv_a(1, 0, 0, 5'd1, 32'h0);
    #1;
    checks++;
    if (pa.gnt !== 1'b1) begin
      errors++;
      $display("FAIL mid_gnt: got %b need 1", pa.gnt);
    end
    @(posedge clk);
    #1;
    checks++;
    if (pa.rvalid !== 1'b1 || pa.rdata !== 32'h05633453) begin
      errors++;
      $display("FAIL mid_pre: got %b %h need 1 05633453",
               pa.rvalid, pa.rdata);
    end
    pa.we = 1;
    drv_b(1, 0, 0, 5'd2, 32'h0);
    rst = 1;
    #1;
    checks++;
    if (pa.gnt !== 1'b0 || pb.gnt !== 1'b0 || dm_we !== 1'b0) begin
      errors++;
      $display("FAIL mid_gnt_off: got %b %b %b need 0 0 0",
               pa.gnt, pb.gnt, dm_we);
    end
    checks++;
    if (pa.rvalid !== 1'b0 || pa.rdata !== 32'h0 ||
        pb.rdata !== 32'h0) begin
      errors++;
      $display("FAIL mid_rdata: got %b %h %h need 0 0 0",
               pa.rvalid, pa.rdata, pb.rdata);
    end
    @(negedge clk);
    idle();
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    drv_a(1, 0, 0, 5'd0, 32'h0);
    drv_b(1, 0, 0, 5'd2, 32'h0);
    #1;
    checks++;
    if (pa.gnt !== 1'b1 || pb.gnt !== 1'b0) begin
      errors++;
      $display("FAIL mid_resume: got a=%b b=%b need 1 0", pa.gnt, pb.gnt);
    end
    @(negedge clk);
    idle();
  endtask

  initial begin
    test_reset();
    test_solo();
    test_tie();
    test_lock();
    test_release();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout need completion");
    $fatal(1);
  end

endmodule
